// File: rtl/ysyx_25040109_pkg.sv
// Shared constants and helpers for the ysyx_25040109 front end.
// Fetch-queue defaults live here so IFU/IDU agree on widths.
package ysyx_25040109_pkg;

    localparam logic [31:0] RESET_PC   = 32'h8000_0000;
    localparam int          DEF_DATA_W = 32;
    localparam int          DEF_PC_W   = 32;
    localparam int          DEF_DEPTH  = 4;

    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

endpackage

// File: rtl/ysyx_25040109_fifo_mem.sv
// Fetch-queue storage: one synchronous write port, asynchronous read.
// Contents are never reset; validity is tracked by the pointers in the top.
module ysyx_25040109_fifo_mem #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64,
    parameter int AW    = 2
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/ysyx_25040109_fetch_queue.sv
// IFU -> IDU instruction/PC queue with flush and saturating drop counter.
// Handshake outputs depend only on registered occupancy and flush.
module ysyx_25040109_fetch_queue
    import ysyx_25040109_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int PC_W   = DEF_PC_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_inst,
    input  logic [PC_W-1:0]   in_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_inst,
    output logic [PC_W-1:0]   out_pc,
    input  logic              flush,
    output logic [CNT_W-1:0]  count,
    output logic [15:0]       flush_drops
);

    localparam int               AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [15:0]      flush_drops_q, flush_drops_d;

    logic in_fire;
    logic out_fire;
    logic [DATA_W+PC_W-1:0] head_entry;

    always_comb begin
        in_ready  = (count_q < FULL_CNT) && !flush;
        out_valid = (count_q != '0) && !flush;
        in_fire   = in_valid && in_ready;
        out_fire  = out_valid && out_ready;

        wptr_d        = wptr_q;
        rptr_d        = rptr_q;
        count_d       = count_q;
        flush_drops_d = flush_drops_q;

        if (flush) begin
            wptr_d        = '0;
            rptr_d        = '0;
            count_d       = '0;
            flush_drops_d = sat_add16(flush_drops_q, 16'(count_q));
        end else begin
            // Power-of-two depth: natural pointer overflow is the mod-DEPTH wrap.
            if (in_fire) begin
                wptr_d = wptr_q + AW'(1);
            end
            if (out_fire) begin
                rptr_d = rptr_q + AW'(1);
            end
            case ({in_fire, out_fire})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q        <= '0;
            rptr_q        <= '0;
            count_q       <= '0;
            flush_drops_q <= '0;
        end else begin
            wptr_q        <= wptr_d;
            rptr_q        <= rptr_d;
            count_q       <= count_d;
            flush_drops_q <= flush_drops_d;
        end
    end

    ysyx_25040109_fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (DATA_W + PC_W),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (in_fire),
        .waddr (wptr_q),
        .wdata ({in_inst, in_pc}),
        .raddr (rptr_q),
        .rdata (head_entry)
    );

    assign out_inst    = head_entry[DATA_W+PC_W-1:PC_W];
    assign out_pc      = head_entry[PC_W-1:0];
    assign count       = count_q;
    assign flush_drops = flush_drops_q;

endmodule
